// File: rtl/pb_select_sequencer.sv
// pb_select_sequencer
//
// Drives the one-hot program-block select vector that steers the
// iteration-condition mux. Only one block's IC signals reach the min/max
// comparator matrix at a time. The sequencer walks blocks 0..num-1. Each block
// is held for its programmed dwell count, and the whole schedule is repeated
// rep times.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   cfg_we        write cfg_dwell into dwell table entry cfg_idx (IDLE only)
//   cfg_idx       dwell table entry to write (>= MAX_NO_OF_PROGRAM_BLOCKS ignored)
//   cfg_dwell     dwell in cycles (0 is stored as 1)
//   cfg_num_pb    number of scheduled blocks, sampled at start
//   cfg_repeat    number of schedule passes, sampled at start
//   start         one-cycle run request (honoured only in IDLE without abort)
//   abort         terminates a run immediately; beats start/enable/completion
//   enable        advance qualifier; low freezes the sequencer
//   sel_o         one-hot block select (bit n = block n), zero when not running
//   pb_idx_o      binary index of the selected block
//   busy_o        high while in RUN
//   pb_change_o   one-cycle pulse when sel_o moves to a new block
//   done_o        one-cycle pulse on normal completion
//   state_o       current FSM state (debug observation)
//
// Control protocol: there is no valid/ready handshake. start, abort and cfg_we
// are single-cycle strobes, sampled on every rising edge. They are accepted
// or ignored depending on the current state. No back-pressure is applied.
module pb_select_sequencer #(
  parameter int MAX_NO_OF_PROGRAM_BLOCKS = 12,
  parameter int CNT_WIDTH                = 16,
  parameter int IDX_W                    = $clog2(MAX_NO_OF_PROGRAM_BLOCKS + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_we,
  input  logic [IDX_W-1:0]                    cfg_idx,
  input  logic [CNT_WIDTH-1:0]                cfg_dwell,
  input  logic [IDX_W-1:0]                    cfg_num_pb,
  input  logic [CNT_WIDTH-1:0]                cfg_repeat,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                enable,
  output logic [MAX_NO_OF_PROGRAM_BLOCKS-1:0] sel_o,
  output logic [IDX_W-1:0]                    pb_idx_o,
  output logic                                busy_o,
  output logic                                pb_change_o,
  output logic                                done_o,
  output logic [1:0]                          state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0]     MAX_IDX = IDX_W'(MAX_NO_OF_PROGRAM_BLOCKS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [MAX_NO_OF_PROGRAM_BLOCKS-1:0] SEL_ONE =
    MAX_NO_OF_PROGRAM_BLOCKS'(1);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] dwell_tab [MAX_NO_OF_PROGRAM_BLOCKS];
  logic [CNT_WIDTH-1:0] dwell_cnt;
  logic [CNT_WIDTH-1:0] rep_cnt;
  logic [IDX_W-1:0]     num_r;

  logic [IDX_W-1:0]     next_idx;
  logic                 last_blk;
  logic [IDX_W-1:0]     num_clamped;
  logic [CNT_WIDTH-1:0] rep_clamped;
  logic [CNT_WIDTH-1:0] dwell_wr;

  always_comb begin
    next_idx = pb_idx_o + IDX_W'(1);
    // Last block of a pass when the next index would reach num.
    last_blk = (next_idx >= num_r);
    num_clamped = cfg_num_pb;
    if (cfg_num_pb == '0) num_clamped = IDX_W'(1);
    else if (cfg_num_pb > MAX_IDX) num_clamped = MAX_IDX;
    rep_clamped = (cfg_repeat == '0) ? CNT_ONE : cfg_repeat;
    dwell_wr    = (cfg_dwell == '0) ? CNT_ONE : cfg_dwell;
  end

  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sel_o       <= '0;
      pb_idx_o    <= '0;
      busy_o      <= 1'b0;
      pb_change_o <= 1'b0;
      done_o      <= 1'b0;
      dwell_cnt   <= '0;
      rep_cnt     <= '0;
      num_r       <= '0;
      for (int i = 0; i < MAX_NO_OF_PROGRAM_BLOCKS; i++) dwell_tab[i] <= CNT_ONE;
    end else begin
      pb_change_o <= 1'b0;
      done_o      <= 1'b0;

      if (state == ST_IDLE && cfg_we && cfg_idx < MAX_IDX)
        dwell_tab[cfg_idx] <= dwell_wr;

      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state       <= ST_RUN;
            num_r       <= num_clamped;
            rep_cnt     <= rep_clamped;
            sel_o       <= SEL_ONE;
            pb_idx_o    <= '0;
            dwell_cnt   <= dwell_tab[0];
            busy_o      <= 1'b1;
            pb_change_o <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state    <= ST_IDLE;
            sel_o    <= '0;
            pb_idx_o <= '0;
            busy_o   <= 1'b0;
          end else if (enable) begin
            if (dwell_cnt > CNT_ONE) begin
              dwell_cnt <= dwell_cnt - CNT_ONE;
            end else if (!last_blk) begin
              sel_o       <= SEL_ONE << next_idx;
              pb_idx_o    <= next_idx;
              dwell_cnt   <= dwell_tab[next_idx];
              pb_change_o <= 1'b1;
            end else if (rep_cnt > CNT_ONE) begin
              sel_o       <= SEL_ONE;
              pb_idx_o    <= '0;
              dwell_cnt   <= dwell_tab[0];
              rep_cnt     <= rep_cnt - CNT_ONE;
              pb_change_o <= 1'b1;
            end else begin
              state    <= ST_DONE;
              sel_o    <= '0;
              pb_idx_o <= '0;
              busy_o   <= 1'b0;
              done_o   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Always returns to IDLE. A start here is dropped, and an abort
          // needs no extra action because done_o is already a single pulse.
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          sel_o    <= '0;
          pb_idx_o <= '0;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pb_select_sequencer.sv
module tb_pb_select_sequencer;

  localparam int MAXPB = 12;
  localparam int CW    = 16;
  localparam int IW    = 4;
  localparam int VW    = MAXPB + IW + 3 + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_we = 1'b0;
  logic [IW-1:0]   cfg_idx = '0;
  logic [CW-1:0]   cfg_dwell = '0;
  logic [IW-1:0]   cfg_num_pb = '0;
  logic [CW-1:0]   cfg_repeat = '0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            enable = 1'b1;
  logic [MAXPB-1:0] sel_o;
  logic [IW-1:0]   pb_idx_o;
  logic            busy_o;
  logic            pb_change_o;
  logic            done_o;
  logic [1:0]      state_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [VW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pb_select_sequencer #(
    .MAX_NO_OF_PROGRAM_BLOCKS(MAXPB),
    .CNT_WIDTH(CW),
    .IDX_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_dwell(cfg_dwell),
    .cfg_num_pb(cfg_num_pb), .cfg_repeat(cfg_repeat),
    .start(start), .abort(abort), .enable(enable),
    .sel_o(sel_o), .pb_idx_o(pb_idx_o), .busy_o(busy_o),
    .pb_change_o(pb_change_o), .done_o(done_o), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  // Expected vector = {sel, idx, busy, change, done, state}
  task automatic chk(input string tag, input logic [MAXPB-1:0] s, input logic [IW-1:0] i,
                     input logic b, input logic c, input logic d, input logic [1:0] st);
    logic [VW-1:0] obs;
    logic [VW-1:0] expv;
    exp_q.push_back({s, i, b, c, d, st});
    expv = exp_q.pop_front();
    obs  = {sel_o, pb_idx_o, busy_o, pb_change_o, done_o, state_o};
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed sel=%b idx=%0d busy=%b chg=%b done=%b st=%0d expected sel=%b idx=%0d busy=%b chg=%b done=%b st=%0d",
             tag, sel_o, pb_idx_o, busy_o, pb_change_o, done_o, state_o, s, i, b, c, d, st);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: strobes set beforehand are applied on this edge then dropped.
  task automatic cyc(input string tag, input logic [MAXPB-1:0] s, input logic [IW-1:0] i,
                     input logic b, input logic c, input logic d, input logic [1:0] st);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    chk(tag, s, i, b, c, d, st);
  endtask

  task automatic wr(input logic [IW-1:0] idx, input logic [CW-1:0] dw);
    cfg_we = 1'b1; cfg_idx = idx; cfg_dwell = dw;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset_state", '0, 0, 0, 0, 0, 0);
    #10 rst_n = 1'b1;
    cyc("idle_after_reset", '0, 0, 0, 0, 0, 0);

    // Basic run: dwell {2,3,1}, 3 blocks, 1 pass
    wr(0, 2); wr(1, 3); wr(2, 1);
    cfg_num_pb = 3; cfg_repeat = 1; enable = 1'b1;
    start = 1'b1;
    cyc("basic_start",  12'b001, 0, 1, 1, 0, 1);
    cyc("basic_b0_c2",  12'b001, 0, 1, 0, 0, 1);
    cyc("basic_b1_c1",  12'b010, 1, 1, 1, 0, 1);
    cyc("basic_b1_c2",  12'b010, 1, 1, 0, 0, 1);
    cyc("basic_b1_c3",  12'b010, 1, 1, 0, 0, 1);
    cyc("basic_b2_c1",  12'b100, 2, 1, 1, 0, 1);
    cyc("basic_done",   '0, 0, 0, 0, 1, 2);
    start = 1'b1;  // start during DONE is ignored
    cyc("basic_idle",   '0, 0, 0, 0, 0, 0);
    cyc("basic_idle2",  '0, 0, 0, 0, 0, 0);

    // Wrap-around: dwell {1,1}, 2 blocks, 3 passes
    wr(0, 1); wr(1, 1);
    cfg_num_pb = 2; cfg_repeat = 3;
    start = 1'b1;
    cyc("wrap_0", 12'b001, 0, 1, 1, 0, 1);
    for (int k = 1; k < 6; k++)
      cyc($sformatf("wrap_%0d", k), (k % 2) ? 12'b010 : 12'b001, IW'(k % 2), 1, 1, 0, 1);
    cyc("wrap_done", '0, 0, 0, 0, 1, 2);
    cyc("wrap_idle", '0, 0, 0, 0, 0, 0);

    // Enable stall during block 1
    wr(0, 2); wr(1, 3); wr(2, 1);
    cfg_num_pb = 3; cfg_repeat = 1;
    start = 1'b1;
    cyc("stall_start", 12'b001, 0, 1, 1, 0, 1);
    cyc("stall_b0_c2", 12'b001, 0, 1, 0, 0, 1);
    cyc("stall_b1_c1", 12'b010, 1, 1, 1, 0, 1);
    enable = 1'b0;
    for (int k = 0; k < 4; k++)
      cyc($sformatf("stall_hold_%0d", k), 12'b010, 1, 1, 0, 0, 1);
    enable = 1'b1;
    cyc("stall_b1_c2", 12'b010, 1, 1, 0, 0, 1);
    cyc("stall_b1_c3", 12'b010, 1, 1, 0, 0, 1);
    cyc("stall_b2",    12'b100, 2, 1, 1, 0, 1);
    cyc("stall_done",  '0, 0, 0, 0, 1, 2);
    cyc("stall_idle",  '0, 0, 0, 0, 0, 0);

    // Abort in 2nd cycle of block 1, with start on the same edge
    start = 1'b1;
    cyc("abort_start", 12'b001, 0, 1, 1, 0, 1);
    cyc("abort_b0_c2", 12'b001, 0, 1, 0, 0, 1);
    cyc("abort_b1_c1", 12'b010, 1, 1, 1, 0, 1);
    cyc("abort_b1_c2", 12'b010, 1, 1, 0, 0, 1);
    abort = 1'b1; start = 1'b1;
    cyc("abort_idle",  '0, 0, 0, 0, 0, 0);
    cyc("abort_stays", '0, 0, 0, 0, 0, 0);

    // Clamping and ignored writes
    wr(0, 0);   // stored as 1
    wr(12, 5);  // out of range, ignored
    cfg_num_pb = 0; cfg_repeat = 0;
    start = 1'b1;
    cyc("clamp_start", 12'b001, 0, 1, 1, 0, 1);
    cfg_we = 1'b1; cfg_idx = 0; cfg_dwell = 7;  // write during RUN, ignored
    cyc("clamp_done",  '0, 0, 0, 0, 1, 2);
    cyc("clamp_idle",  '0, 0, 0, 0, 0, 0);
    cfg_num_pb = 1; cfg_repeat = 1;
    start = 1'b1;
    cyc("tab_start",   12'b001, 0, 1, 1, 0, 1);
    cyc("tab_done",    '0, 0, 0, 0, 1, 2);
    cyc("tab_idle",    '0, 0, 0, 0, 0, 0);

    // Upper clamp: num 15 -> 12 blocks, dwell 1 each except block 1 (3)
    cfg_num_pb = 15;
    start = 1'b1;
    cyc("max_b0", 12'b000000000001, 0, 1, 1, 0, 1);
    cyc("max_b1", 12'b000000000010, 1, 1, 1, 0, 1);
    cyc("max_b1h", 12'b000000000010, 1, 1, 0, 0, 1);
    cyc("max_b1h2", 12'b000000000010, 1, 1, 0, 0, 1);
    for (int k = 2; k < 12; k++)
      cyc($sformatf("max_b%0d", k), MAXPB'(1) << k, IW'(k), 1, 1, 0, 1);
    cyc("max_done", '0, 0, 0, 0, 1, 2);
    cyc("max_idle", '0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-run
    wr(0, 3); wr(1, 3);
    cfg_num_pb = 2; cfg_repeat = 1;
    start = 1'b1;
    cyc("ares_start", 12'b001, 0, 1, 1, 0, 1);
    cyc("ares_b0_c2", 12'b001, 0, 1, 0, 0, 1);
    #3 rst_n = 1'b0;
    #1 chk("ares_immediate", '0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    cyc("ares_idle", '0, 0, 0, 0, 0, 0);
    start = 1'b1;
    cyc("ares_def_b0", 12'b001, 0, 1, 1, 0, 1);
    cyc("ares_def_b1", 12'b010, 1, 1, 1, 0, 1);
    cyc("ares_def_done", '0, 0, 0, 0, 1, 2);
    cyc("ares_def_idle", '0, 0, 0, 0, 0, 0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
